// File: rtl/xbar_pkg.sv
// xbar_pkg -- shared types and defaults for the crossbar reorder-buffer channel.
//   slot_state_e : per-slot lifecycle (FREE -> ALLOC -> FILLED -> FREE)
//   XBAR_NUM_CH  : default channel count
//   XBAR_DATA_W  : default payload width
//   clog2_min1   : ceil(log2(n)) clamped to at least 1 bit
package xbar_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_ALLOC  = 2'd1,
    SLOT_FILLED = 2'd2
  } slot_state_e;

  localparam int XBAR_NUM_CH = 4;
  localparam int XBAR_DATA_W = 128;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xbar_rob_channel_if.sv
// xbar_rob_channel_if -- bundle of the bank-response, allocation and drain
// handshakes of one reorder-buffer channel.
//   bank_sc_xbar_*   : NUM_BANKS flattened response ports (bank b at [b*W +: W])
//   alloc_*          : slot allocation handshake, returns tag in alloc_rob_num_o
//   out_*            : in-order drain handshake
//   err_o            : sticky protocol-error flag
// slave  = channel side, master = producer/consumer side.
interface xbar_rob_channel_if #(
  parameter int NUM_BANKS = 4,
  parameter int CH_W      = 2,
  parameter int PTR_W     = 3,
  parameter int DATA_W    = 128
) ();

  logic [NUM_BANKS-1:0]        bank_sc_xbar_valid_i;
  logic [NUM_BANKS-1:0]        bank_sc_xbar_allowIn_o;
  logic [NUM_BANKS*CH_W-1:0]   bank_sc_xbar_ch_id_i;
  logic [NUM_BANKS*PTR_W-1:0]  bank_sc_xbar_rob_num_i;
  logic [NUM_BANKS*DATA_W-1:0] bank_sc_xbar_data_i;

  logic                        alloc_valid_i;
  logic                        alloc_ready_o;
  logic [PTR_W-1:0]            alloc_rob_num_o;

  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [DATA_W-1:0]           out_data_o;
  logic [PTR_W-1:0]            out_rob_num_o;

  logic                        err_o;

  modport slave (
    input  bank_sc_xbar_valid_i, bank_sc_xbar_ch_id_i, bank_sc_xbar_rob_num_i,
           bank_sc_xbar_data_i, alloc_valid_i, out_ready_i,
    output bank_sc_xbar_allowIn_o, alloc_ready_o, alloc_rob_num_o,
           out_valid_o, out_data_o, out_rob_num_o, err_o
  );

  modport master (
    output bank_sc_xbar_valid_i, bank_sc_xbar_ch_id_i, bank_sc_xbar_rob_num_i,
           bank_sc_xbar_data_i, alloc_valid_i, out_ready_i,
    input  bank_sc_xbar_allowIn_o, alloc_ready_o, alloc_rob_num_o,
           out_valid_o, out_data_o, out_rob_num_o, err_o
  );

endinterface

// File: rtl/rob_storage.sv
// rob_storage -- ROB_DEPTH x DATA_W payload array.
//   clk_i   : clock
//   we_i    : per-bank write enable (already filtered to legal, unique slots)
//   waddr_i : per-bank slot index
//   wdata_i : per-bank payload
//   raddr_i : asynchronous read address (drain head)
//   rdata_o : payload at raddr_i
// No reset: contents are only observed once a slot has been FILLED.
module rob_storage #(
  parameter int NUM_BANKS = 4,
  parameter int ROB_DEPTH = 8,
  parameter int DATA_W    = 128,
  localparam int PTR_W    = $clog2(ROB_DEPTH)
) (
  input  logic                                clk_i,
  input  logic [NUM_BANKS-1:0]                we_i,
  input  logic [NUM_BANKS-1:0][PTR_W-1:0]     waddr_i,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]    wdata_i,
  input  logic [PTR_W-1:0]                    raddr_i,
  output logic [DATA_W-1:0]                   rdata_o
);

  logic [DATA_W-1:0] mem_q [ROB_DEPTH];

  // Enables are unique per slot upstream; descending order keeps the lowest
  // bank as the final writer should that ever not hold.
  always_ff @(posedge clk_i) begin
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (we_i[b]) mem_q[waddr_i[b]] <= wdata_i[b];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xbar_rob_channel.sv
// xbar_rob_channel -- per-channel reorder buffer behind a bank crossbar.
//   clk_i  : clock, all state on rising edge
//   rst_i  : synchronous active-high reset
//   bus_if : xbar_rob_channel_if.slave
//     bank_sc_xbar_* : bank responses; only those tagged with CHANNEL_ID land here
//     alloc_*        : hands out slot tags in order, ready while not full
//     out_*          : releases filled slots strictly in allocation order
//     err_o          : sticky; set by writes to non-ALLOC slots or slot collisions
module xbar_rob_channel
  import xbar_pkg::*;
#(
  parameter int CHANNEL_ID = 0,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_CH     = XBAR_NUM_CH,
  parameter int ROB_DEPTH  = 8,
  parameter int DATA_W     = XBAR_DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  xbar_rob_channel_if.slave bus_if
);

  localparam int CH_W  = clog2_min1(NUM_CH);
  localparam int PTR_W = $clog2(ROB_DEPTH);
  localparam logic [CH_W-1:0]  MY_CH   = CH_W'(CHANNEL_ID);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(ROB_DEPTH);

  // bank views of the flattened ports
  logic [NUM_BANKS-1:0][CH_W-1:0]   bk_ch;
  logic [NUM_BANKS-1:0][PTR_W-1:0]  bk_rob;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bk_data;

  assign bk_ch   = bus_if.bank_sc_xbar_ch_id_i;
  assign bk_rob  = bus_if.bank_sc_xbar_rob_num_i;
  assign bk_data = bus_if.bank_sc_xbar_data_i;

  slot_state_e      slot_q [ROB_DEPTH];
  slot_state_e      slot_d [ROB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q, err_d;

  logic [NUM_BANKS-1:0] we_raw;   // addressed to this channel
  logic [NUM_BANKS-1:0] dup;      // a lower bank hits the same slot this cycle
  logic [NUM_BANKS-1:0] wr_ok;    // accepted writes
  logic                 wr_err;

  logic alloc_ready, alloc_fire;
  logic out_valid, drain_fire;
  logic [DATA_W-1:0] rd_data;

  // writes arriving during reset are discarded
  always_comb begin
    we_raw = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      we_raw[b] = bus_if.bank_sc_xbar_valid_i[b] && (bk_ch[b] == MY_CH) && !rst_i;
  end

  always_comb begin
    dup = '0;
    for (int b = 1; b < NUM_BANKS; b++)
      for (int c = 0; c < b; c++)
        if (we_raw[b] && we_raw[c] && (bk_rob[c] == bk_rob[b])) dup[b] = 1'b1;
  end

  // A slot allocated this same edge is still FREE in slot_q, so it is
  // rejected here without a dedicated check.
  always_comb begin
    wr_ok  = '0;
    wr_err = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (we_raw[b]) begin
        if (!dup[b] && (slot_q[bk_rob[b]] == SLOT_ALLOC)) wr_ok[b] = 1'b1;
        else                                              wr_err   = 1'b1;
      end
    end
  end

  // Gated by registered count only: a same-cycle drain never opens a slot.
  assign alloc_ready = (count_q < DEPTH_C);
  assign alloc_fire  = bus_if.alloc_valid_i && alloc_ready;
  assign out_valid   = (slot_q[head_q] == SLOT_FILLED);
  assign drain_fire  = out_valid && bus_if.out_ready_i;

  // Drain (head FILLED), alloc (tail FREE) and writes (ALLOC) touch slots in
  // disjoint states, so their updates never collide.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) slot_d[i] = slot_q[i];
    for (int b = 0; b < NUM_BANKS; b++)
      if (wr_ok[b]) slot_d[bk_rob[b]] = SLOT_FILLED;
    if (drain_fire) slot_d[head_q] = SLOT_FREE;
    if (alloc_fire) slot_d[tail_q] = SLOT_ALLOC;
  end

  always_comb begin
    head_d  = drain_fire ? PTR_W'(head_q + 1'b1) : head_q;
    tail_d  = alloc_fire ? PTR_W'(tail_q + 1'b1) : tail_q;
    count_d = count_q;
    case ({alloc_fire, drain_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    err_d = err_q | wr_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < ROB_DEPTH; i++) slot_q[i] <= SLOT_FREE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < ROB_DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  rob_storage #(
    .NUM_BANKS (NUM_BANKS),
    .ROB_DEPTH (ROB_DEPTH),
    .DATA_W    (DATA_W)
  ) u_storage (
    .clk_i   (clk_i),
    .we_i    (wr_ok),
    .waddr_i (bk_rob),
    .wdata_i (bk_data),
    .raddr_i (head_q),
    .rdata_o (rd_data)
  );

  assign bus_if.bank_sc_xbar_allowIn_o = {NUM_BANKS{~rst_i}};
  assign bus_if.alloc_ready_o          = alloc_ready;
  assign bus_if.alloc_rob_num_o        = tail_q;
  assign bus_if.out_valid_o            = out_valid;
  assign bus_if.out_data_o             = rd_data;
  assign bus_if.out_rob_num_o          = head_q;
  assign bus_if.err_o                  = err_q;

endmodule

// File: tb/tb_xbar_rob_channel.sv
module tb_xbar_rob_channel;

  localparam int NB  = 4;
  localparam int CHW = 2;
  localparam int PW  = 3;
  localparam int DW  = 128;
  localparam logic [1:0] MYCH = 2'd2;
  localparam logic [1:0] OTCH = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbar_rob_channel_if #(.NUM_BANKS(NB), .CH_W(CHW), .PTR_W(PW), .DATA_W(DW)) bif ();

  xbar_rob_channel #(
    .CHANNEL_ID (2),
    .NUM_BANKS  (NB),
    .NUM_CH     (4),
    .ROB_DEPTH  (8),
    .DATA_W     (DW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: tags pushed at allocation, expected payload recorded at fill
  logic [PW-1:0] exp_q [$];
  logic [DW-1:0] exp_data [8];
  logic [PW-1:0] m_tail;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_banks();
    bif.bank_sc_xbar_valid_i  = '0;
    bif.bank_sc_xbar_ch_id_i  = '0;
    bif.bank_sc_xbar_rob_num_i = '0;
    bif.bank_sc_xbar_data_i   = '0;
  endtask

  task automatic set_bank(input int b, input logic [1:0] ch, input logic [2:0] rob,
                          input logic [DW-1:0] d);
    bif.bank_sc_xbar_valid_i[b]             = 1'b1;
    bif.bank_sc_xbar_ch_id_i[b*CHW +: CHW]  = ch;
    bif.bank_sc_xbar_rob_num_i[b*PW +: PW]  = rob;
    bif.bank_sc_xbar_data_i[b*DW +: DW]     = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.alloc_valid_i = 1'b0;
    bif.out_ready_i   = 1'b0;
    clear_banks();
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_tail = '0;
  endtask

  task automatic alloc_n(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      bif.alloc_valid_i = 1'b1;
      #1;
      n_checks++;
      if (bif.alloc_ready_o !== 1'b1 || bif.alloc_rob_num_o !== m_tail) begin
        n_fail++;
        $display("FAIL %s alloc%0d: ready=%b tag=%0d, want ready=1 tag=%0d",
                 nm, i, bif.alloc_ready_o, bif.alloc_rob_num_o, m_tail);
      end
      exp_q.push_back(m_tail);
      m_tail = m_tail + 1'b1;
      tick();
      bif.alloc_valid_i = 1'b0;
    end
  endtask

  // pop one expected tag and compare the drained slot against it
  task automatic sb_drain(input string nm);
    logic [PW-1:0] t;
    bif.out_ready_i = 1'b1;
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty at drain, valid=%b", nm, bif.out_valid_o);
    end else begin
      t = exp_q.pop_front();
      if (bif.out_valid_o !== 1'b1 || bif.out_rob_num_o !== t ||
          bif.out_data_o !== exp_data[t]) begin
        n_fail++;
        $display("FAIL %s: valid=%b rob=%0d data=%h, want valid=1 rob=%0d data=%h",
                 nm, bif.out_valid_o, bif.out_rob_num_o, bif.out_data_o, t, exp_data[t]);
      end
    end
    tick();
    bif.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.alloc_valid_i = 1'b0;
    bif.out_ready_i   = 1'b0;
    clear_banks();
    tick();
    n_checks++;
    if (bif.bank_sc_xbar_allowIn_o !== 4'h0 || bif.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: allowIn=%h out_valid=%b, want 0/0",
               bif.bank_sc_xbar_allowIn_o, bif.out_valid_o);
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_tail = '0;
    #1;
    n_checks++;
    if (bif.bank_sc_xbar_allowIn_o !== 4'hF || bif.alloc_ready_o !== 1'b1 ||
        bif.alloc_rob_num_o !== 3'd0 || bif.err_o !== 1'b0 || bif.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: allowIn=%h ready=%b tag=%0d err=%b valid=%b, want F/1/0/0/0",
               bif.bank_sc_xbar_allowIn_o, bif.alloc_ready_o, bif.alloc_rob_num_o,
               bif.err_o, bif.out_valid_o);
    end
  endtask

  task automatic test_alloc_full();
    do_reset();
    alloc_n(8, "alloc_full");
    bif.alloc_valid_i = 1'b1;
    #1;
    n_checks++;
    if (bif.alloc_ready_o !== 1'b0 || bif.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc_full_ready: ready=%b valid=%b, want 0/0",
               bif.alloc_ready_o, bif.out_valid_o);
    end
    tick();
    bif.alloc_valid_i = 1'b0;
  endtask

  task automatic test_ooo_fill();
    logic [DW-1:0] d;
    do_reset();
    alloc_n(4, "ooo_alloc");
    d = rnd128(); exp_data[3] = d; set_bank(2, MYCH, 3'd3, d);
    tick(); clear_banks();
    n_checks++;
    if (bif.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ooo_hold3: out_valid=%b, want 0", bif.out_valid_o);
    end
    d = rnd128(); exp_data[1] = d; set_bank(0, MYCH, 3'd1, d);
    tick(); clear_banks();
    n_checks++;
    if (bif.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL ooo_hold1: out_valid=%b, want 0", bif.out_valid_o);
    end
    d = rnd128(); exp_data[0] = d; set_bank(1, MYCH, 3'd0, d);
    d = rnd128(); exp_data[2] = d; set_bank(3, MYCH, 3'd2, d);
    tick(); clear_banks();
    for (int i = 0; i < 4; i++) sb_drain($sformatf("ooo_drain%0d", i));
    n_checks++;
    if (bif.out_valid_o !== 1'b0 || bif.err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_end: valid=%b err=%b, want 0/0", bif.out_valid_o, bif.err_o);
    end
  endtask

  task automatic test_other_channel();
    logic [DW-1:0] d;
    do_reset();
    alloc_n(1, "other_alloc");
    set_bank(1, OTCH, 3'd0, rnd128());
    tick(); clear_banks();
    n_checks++;
    if (bif.out_valid_o !== 1'b0 || bif.err_o !== 1'b0 || bif.bank_sc_xbar_allowIn_o !== 4'hF) begin
      n_fail++;
      $display("FAIL other_ch: valid=%b err=%b allowIn=%h, want 0/0/F",
               bif.out_valid_o, bif.err_o, bif.bank_sc_xbar_allowIn_o);
    end
    d = rnd128(); exp_data[0] = d; set_bank(1, MYCH, 3'd0, d);
    tick(); clear_banks();
    sb_drain("other_then_legal");
  endtask

  task automatic test_dup_write();
    logic [DW-1:0] d;
    do_reset();
    alloc_n(6, "dup_alloc");
    for (int b = 0; b < 4; b++) begin
      d = rnd128(); exp_data[b] = d; set_bank(b, MYCH, 3'(b), d);
    end
    tick(); clear_banks();
    n_checks++;
    if (bif.err_o !== 1'b0 || bif.out_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_distinct: err=%b valid=%b, want 0/1", bif.err_o, bif.out_valid_o);
    end
    d = rnd128(); exp_data[4] = d; set_bank(0, MYCH, 3'd4, d);
    tick(); clear_banks();
    d = rnd128(); exp_data[5] = d; set_bank(0, MYCH, 3'd5, d);
    set_bank(3, MYCH, 3'd5, rnd128());
    tick(); clear_banks();
    n_checks++;
    if (bif.err_o !== 1'b1) begin
      n_fail++; $display("FAIL dup_err: err=%b, want 1", bif.err_o);
    end
    for (int i = 0; i < 6; i++) sb_drain($sformatf("dup_drain%0d", i));
    n_checks++;
    if (bif.err_o !== 1'b1) begin
      n_fail++; $display("FAIL dup_err_sticky: err=%b, want 1", bif.err_o);
    end
  endtask

  task automatic test_stall_wrap();
    logic [DW-1:0] d;
    logic [PW-1:0] t;
    do_reset();
    alloc_n(8, "stall_alloc");
    for (int c = 0; c < 2; c++) begin
      for (int b = 0; b < 4; b++) begin
        d = rnd128(); exp_data[c*4+b] = d; set_bank(b, MYCH, 3'(c*4+b), d);
      end
      tick(); clear_banks();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bif.out_valid_o !== 1'b1 || bif.out_rob_num_o !== 3'd0 ||
          bif.out_data_o !== exp_data[0]) begin
        n_fail++;
        $display("FAIL stall%0d: valid=%b rob=%0d data=%h, want 1/0/%h",
                 i, bif.out_valid_o, bif.out_rob_num_o, bif.out_data_o, exp_data[0]);
      end
      tick();
    end
    // full: drain fires, alloc must not
    bif.alloc_valid_i = 1'b1;
    #1;
    n_checks++;
    if (bif.alloc_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL full_no_bypass: ready=%b, want 0", bif.alloc_ready_o);
    end
    sb_drain("stall_drain0");
    // drain slot 1 and allocate wrapped tag 0 on the same edge
    bif.out_ready_i = 1'b1;
    #1;
    t = exp_q.pop_front();
    n_checks++;
    if (bif.alloc_ready_o !== 1'b1 || bif.alloc_rob_num_o !== m_tail ||
        bif.out_rob_num_o !== t || bif.out_data_o !== exp_data[t]) begin
      n_fail++;
      $display("FAIL drain_alloc: ready=%b tag=%0d rob=%0d data=%h, want 1/%0d/%0d/%h",
               bif.alloc_ready_o, bif.alloc_rob_num_o, bif.out_rob_num_o,
               bif.out_data_o, m_tail, t, exp_data[t]);
    end
    exp_q.push_back(m_tail);
    m_tail = m_tail + 1'b1;
    tick();
    bif.alloc_valid_i = 1'b0;
    bif.out_ready_i   = 1'b0;
    // count held at 7 through the simultaneous edge: one more alloc fills it
    alloc_n(1, "refill");
    #1;
    n_checks++;
    if (bif.alloc_ready_o !== 1'b0 || bif.out_rob_num_o !== 3'd2) begin
      n_fail++;
      $display("FAIL count_after_swap: ready=%b head=%0d, want 0/2",
               bif.alloc_ready_o, bif.out_rob_num_o);
    end
  endtask

  task automatic test_illegal_write();
    logic [DW-1:0] d;
    do_reset();
    set_bank(0, MYCH, 3'd6, rnd128());
    tick(); clear_banks();
    n_checks++;
    if (bif.err_o !== 1'b1 || bif.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL free_write: err=%b valid=%b, want 1/0", bif.err_o, bif.out_valid_o);
    end
    do_reset();
    n_checks++;
    if (bif.err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared: err=%b, want 0", bif.err_o);
    end
    // write into the slot being allocated on this very edge
    bif.alloc_valid_i = 1'b1;
    set_bank(1, MYCH, 3'd0, rnd128());
    tick(); clear_banks();
    bif.alloc_valid_i = 1'b0;
    exp_q.push_back(m_tail);
    m_tail = m_tail + 1'b1;
    n_checks++;
    if (bif.err_o !== 1'b1 || bif.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_alloc_write: err=%b valid=%b, want 1/0",
               bif.err_o, bif.out_valid_o);
    end
    d = rnd128(); exp_data[0] = d; set_bank(1, MYCH, 3'd0, d);
    tick(); clear_banks();
    sb_drain("late_legal_fill");
    alloc_n(3, "pre_rst");
    do_reset();
    #1;
    n_checks++;
    if (bif.err_o !== 1'b0 || bif.out_valid_o !== 1'b0 || bif.alloc_ready_o !== 1'b1 ||
        bif.alloc_rob_num_o !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_pulse: err=%b valid=%b ready=%b tag=%0d, want 0/0/1/0",
               bif.err_o, bif.out_valid_o, bif.alloc_ready_o, bif.alloc_rob_num_o);
    end
    alloc_n(8, "post_rst_alloc");
    #1;
    n_checks++;
    if (bif.alloc_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_full: ready=%b, want 0", bif.alloc_ready_o);
    end
  endtask

  initial begin
    bif.alloc_valid_i = 1'b0;
    bif.out_ready_i   = 1'b0;
    clear_banks();
    m_tail = '0;
    test_reset();
    test_alloc_full();
    test_ooo_fill();
    test_other_channel();
    test_dup_write();
    test_stall_wrap();
    test_illegal_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
